// File: rtl/mem_access_stage_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state type for the request/grant/response handshake
//   - be_for():     byte enables for a given size and byte offset
//   - misaligned(): alignment fault detection for a given size and byte offset
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Little-endian lane selection; the reserved size code falls into the word case.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: be_for = 4'b0001 << addr;
            SZ_HALF: be_for = 4'b0011 << {addr[1], 1'b0};
            default: be_for = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            default: misaligned = |addr;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load data extraction.
//   rdata    in  32 : raw word returned by data memory
//   addr     in  2  : byte offset of the access within the word
//   size     in  2  : access size (byte / half / word)
//   zero_ext in  1  : 1 = zero-extend, 0 = sign-extend
//   data     out 32 : extended load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Move the addressed byte/half down to bit 0 before extending.
    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SZ_BYTE: data = zero_ext ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = zero_ext ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage after the execute ALU.
//   ex_*   : instruction from execute (valid/ready handshake, ALU result,
//            store data, load/store flags, size, unsigned, rd, reg_write)
//   dmem_* : request/grant/response interface to data memory; request
//            fields are registered and held stable until dmem_gnt
//   wb_*   : registered write-back record, one wb_valid pulse per instruction
//   mem_exc: pulses with wb_valid when the access faulted (misaligned or
//            read+write both set); no memory request is issued in that case
// ex_ready depends on the FSM state only, so there is no combinational path
// from the dmem_* inputs back to execute.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              mem_exc
);

    state_t      state_reg, state_next;

    logic        accept;
    logic        is_mem;
    logic        fault;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    // Access context latched at accept, used for the response and write-back.
    logic [1:0]  off_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic        load_reg;
    logic [4:0]  rd_reg;
    logic        regw_reg;

    assign ex_ready = (state_reg == ST_IDLE);
    assign accept   = ex_valid & ex_ready;
    assign is_mem   = ex_mem_read | ex_mem_write;
    assign fault    = is_mem & ((ex_mem_read & ex_mem_write) |
                                misaligned(ex_size, ex_alu_result[1:0]));

    // Store data lane replication: each byte lane picks its source byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_next[8*gi +: 8] =
                (ex_size == SZ_BYTE) ? ex_store_data[7:0] :
                (ex_size == SZ_HALF) ? ex_store_data[8*(gi%2) +: 8] :
                                       ex_store_data[8*gi +: 8];
        end
    endgenerate

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .addr     (off_reg),
        .size     (size_reg),
        .zero_ext (uns_reg),
        .data     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && is_mem && !fault) state_next = ST_REQ;
            ST_REQ:  if (dmem_gnt) state_next = load_reg ? ST_RESP : ST_IDLE;
            ST_RESP: if (dmem_rvalid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            mem_exc      <= 1'b0;
            off_reg      <= '0;
            size_reg     <= '0;
            uns_reg      <= 1'b0;
            load_reg     <= 1'b0;
            rd_reg       <= '0;
            regw_reg     <= 1'b0;
        end else begin
            // Write-back strobes are single-cycle pulses.
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_exc      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_result;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= ex_reg_write;
                        end else if (fault) begin
                            // Report the faulting address as the write-back value.
                            wb_valid <= 1'b1;
                            mem_exc  <= 1'b1;
                            wb_data  <= ex_alu_result;
                            wb_rd    <= ex_rd;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_write;
                            dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            dmem_wdata <= wdata_next;
                            dmem_be    <= be_for(ex_size, ex_alu_result[1:0]);
                            off_reg    <= ex_alu_result[1:0];
                            size_reg   <= ex_size;
                            uns_reg    <= ex_unsigned;
                            load_reg   <= ex_mem_read;
                            rd_reg     <= ex_rd;
                            regw_reg   <= ex_reg_write;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= '0;
                        if (!load_reg) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_reg;
                        end
                    end
                end
                ST_RESP: begin
                    // rvalid is only sampled here; an rvalid alongside gnt is dropped.
                    if (dmem_rvalid) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= load_data;
                        wb_rd        <= rd_reg;
                        wb_reg_write <= regw_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the execute-stage ALU. It consumes the ALU result, either as a data-memory address for loads and stores or as a pass-through value for all other instructions. It runs the request/grant/response handshake with data memory, performs little-endian byte-lane steering and load extension, and presents one registered write-back record per accepted instruction. It stalls execute via `ex_ready` while a memory access is in flight.

## Interface
- `ADDR_W`, 32: address width; `dmem_addr` is word-aligned (bits [1:0] forced 0).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: stage accepts this cycle; transfer occurs when `ex_valid & ex_ready`.
- `ex_alu_result` in 32: ALU result, used as address or pass-through value.
- `ex_store_data` in 32: store source register value.
- `ex_mem_read` in 1: load.
- `ex_mem_write` in 1: store.
- `ex_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `ex_unsigned` in 1: zero-extend loads.
- `ex_rd` in 5: destination register.
- `ex_reg_write` in 1: instruction writes `rd`.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: request is a write.
- `dmem_addr` out ADDR_W: word address.
- `dmem_wdata` out 32: store data, lane-replicated.
- `dmem_be` out 4: byte enables.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_data` out 32: write-back value.
- `wb_rd` out 5: destination register.
- `wb_reg_write` out 1: write enable, qualified by `wb_valid`.
- `mem_exc` out 1: one-cycle pulse coincident with `wb_valid` on an access fault.

## Operation
- **States:**
  - `IDLE`: `ex_ready` = 1.
  - `REQ`: `dmem_req` = 1; `ex_ready` = 0.
  - `RESP`: waiting for `dmem_rvalid`; `ex_ready` = 0.
- **Non-memory op accepted in IDLE:** registered to WB next cycle.
  - `wb_data` = `ex_alu_result`.
  - FSM stays in IDLE, giving throughput of one per cycle.
- **Fault on accept:** misaligned half (addr[0]=1), misaligned word (addr[1:0]≠0), or `ex_mem_read & ex_mem_write` both set.
  - No memory request is issued.
  - Next cycle: `wb_valid`=1, `mem_exc`=1, `wb_reg_write`=0.
- **Valid load or store:** latch address, size, unsigned, rd, reg_write and store data, then go to REQ.
  - `dmem_*` outputs are driven from the latched values and held stable until `dmem_gnt`.
- **REQ with `dmem_gnt`:**
  - Store → IDLE, with a WB pulse next cycle (`wb_reg_write`=0).
  - Load → RESP.
- **RESP with `dmem_rvalid`:** → IDLE. Next cycle `wb_valid`=1 with extracted data.
- **Byte enables:**
  - Byte: `dmem_be` = 0001<<a[1:0].
  - Half: 0011<<(2·a[1]).
  - Word: 1111.
- **Store data replication:**
  - Byte: `dmem_wdata` = {4{sd[7:0]}}.
  - Half: {2{sd[15:0]}}.
  - Word: sd.
- **Load extraction:** `dmem_rdata` >> (8·a[1:0]), then sign-extend or zero-extend from bit 7 or bit 15 per `ex_unsigned`.
- **Response sampling:** `dmem_rvalid` outside RESP is ignored, including an rvalid in the same cycle as gnt.

## Timing
- **Reset values:**
  - State IDLE.
  - `ex_ready`=1.
  - `dmem_req`, `dmem_we`, `dmem_be` = 0; `dmem_addr`, `dmem_wdata` = 0.
  - `wb_valid`, `wb_reg_write`, `mem_exc` = 0; `wb_data`, `wb_rd` = 0.
- **Latency from accept edge to `wb_valid`:**
  - Non-memory op: 1 cycle.
  - Fault: 1 cycle.
  - Store: minimum 2 cycles (+1 per gnt wait).
  - Load: minimum 3 cycles (+gnt wait +rvalid wait).
- **`ex_ready`:** combinational from state only, with no path from `dmem_*` inputs. It rises the cycle after the completing gnt (store) or rvalid (load).
- **`wb_valid`:** never high for two cycles from one instruction. A back-to-back non-memory op may follow immediately.
- **Reset mid-transaction:** abandons the access. `dmem_req` drops asynchronously, and any later gnt/rvalid is ignored.

## Structure
- **Package `mem_pkg`:** size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum, and a `be_for(size, addr)` function.
- **Sub-module `load_align`:** purely combinational; takes `rdata`, `addr[1:0]`, `size`, `unsigned` and returns the extended 32-bit value. It is instantiated once on the RESP data path.

## Test plan
- Reset, then `ex_alu_result`=0x0000_1234 non-memory with rd=5 → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, no `dmem_req`.
- Load byte at 0x103, signed; gnt immediate; rvalid one cycle later with rdata=0x80AB_CDEF → `dmem_be`=1000, `dmem_addr`=0x100, `wb_data`=0xFFFF_FF80, 3-cycle latency.
- Store half at 0x202, sd=0x1234_BEEF; gnt held off 2 cycles → `dmem_be`=1100, `dmem_wdata`=0xBEEF_BEEF, outputs stable during wait, `ex_ready`=0 until the cycle after gnt.
- Word load at 0x101 → `mem_exc`=1 with `wb_valid`, no `dmem_req`; same for read+write both set.
- Load half unsigned at 0x002 with rdata=0xFFFF_0000 → `wb_data`=0x0000_FFFF; a spurious rvalid while in IDLE produces no `wb_valid`.
- Assert `rst_n`=0 while in RESP, then deliver rvalid after release → no `wb_valid`, all outputs at reset values, `ex_ready`=1.
